// File: rtl/peripheral_mpram_master.sv
// ---------------------------------------------------------------------------
// peripheral_mpram_master
//
// Initiator side of the MPRAM RAM port. Turns a valid/ready request stream
// into registered ram_cen/ram_wen/ram_addr/ram_din cycles, and returns read
// data on a valid/ready response stream. Only one read may be outstanding.
// Writes can issue once per cycle.
//
// Optional feature (compile-time macro MPRAM_INIT_CLEAR_EN):
//   When MPRAM_INIT_CLEAR_EN is defined, the block zero-fills RAM words
//   0..CLR_LAST after each reset release, one word per cycle.
//   While this clear sequence runs, busy=1 and req_ready=0.
//   When the macro is undefined, the block resets straight into IDLE and
//   busy is tied low.
//
// Parameters
//   AW        RAM word address width
//   DW        RAM data width (two byte lanes of DW/2 bits)
//   MEM_SIZE  memory size in bytes (bounds the clear range)
//
// Ports
//   ram_clk    clock; all logic uses the rising edge
//   ram_rst    asynchronous, active-high reset
//   req_valid  request valid
//   req_ready  request accepted when req_valid & req_ready
//   req_we     1 = write, 0 = read
//   req_be     byte enables, active-high ([1] = upper byte)
//   req_addr   word address
//   req_wdata  write data
//   rsp_valid  read data valid
//   rsp_ready  response consumed when rsp_valid & rsp_ready
//   rsp_rdata  read data
//   busy       clear sequence in progress
//   ram_addr   RAM address (registered)
//   ram_din    RAM write data (registered)
//   ram_cen    RAM chip enable, active-low (registered)
//   ram_wen    RAM byte write enables, active-low (registered)
//   ram_dout   RAM read data, valid one cycle after the access edge
// ---------------------------------------------------------------------------
module peripheral_mpram_master #(
  parameter int AW       = 6,
  parameter int DW       = 16,
  parameter int MEM_SIZE = 256
) (
  input  logic          ram_clk,
  input  logic          ram_rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [1:0]    req_be,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_rdata,
  output logic          busy,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  output logic          ram_cen,
  output logic [1:0]    ram_wen,
  input  logic [DW-1:0] ram_dout
);

  typedef enum logic [1:0] {
    ST_CLEAR    = 2'd0,
    ST_IDLE     = 2'd1,
    ST_RD_WAIT  = 2'd2,
    ST_RSP_HOLD = 2'd3
  } state_t;

  state_t        state_reg;
  logic          ram_cen_reg;
  logic [1:0]    ram_wen_reg;
  logic [AW-1:0] ram_addr_reg;
  logic [DW-1:0] ram_din_reg;
  logic          rsp_valid_reg;
  logic [DW-1:0] rsp_rdata_reg;

`ifdef MPRAM_INIT_CLEAR_EN
  // The clear range is capped by both the byte size and the address space.
  localparam int CLR_WORDS = ((MEM_SIZE / 2) < (1 << AW)) ? (MEM_SIZE / 2) : (1 << AW);
  localparam logic [AW-1:0] CLR_LAST = AW'(CLR_WORDS - 1);

  logic [AW-1:0] clr_cnt_reg;
  logic          busy_reg;

  assign busy = busy_reg;
`else
  assign busy = 1'b0;
`endif

  assign req_ready = (state_reg == ST_IDLE);
  assign rsp_valid = rsp_valid_reg;
  assign rsp_rdata = rsp_rdata_reg;
  assign ram_cen   = ram_cen_reg;
  assign ram_wen   = ram_wen_reg;
  assign ram_addr  = ram_addr_reg;
  assign ram_din   = ram_din_reg;

  always_ff @(posedge ram_clk or posedge ram_rst) begin
    if (ram_rst) begin
`ifdef MPRAM_INIT_CLEAR_EN
      state_reg   <= ST_CLEAR;
      clr_cnt_reg <= '0;
      busy_reg    <= 1'b1;
`else
      state_reg   <= ST_IDLE;
`endif
      ram_cen_reg   <= 1'b1;
      ram_wen_reg   <= 2'b11;
      ram_addr_reg  <= '0;
      ram_din_reg   <= '0;
      rsp_valid_reg <= 1'b0;
      rsp_rdata_reg <= '0;
    end else begin
      // Default: no access this cycle. The address and data registers hold.
      ram_cen_reg <= 1'b1;
      ram_wen_reg <= 2'b11;

      case (state_reg)
        ST_CLEAR: begin
`ifdef MPRAM_INIT_CLEAR_EN
          ram_cen_reg  <= 1'b0;
          ram_wen_reg  <= 2'b00;
          ram_din_reg  <= '0;
          ram_addr_reg <= clr_cnt_reg;
          clr_cnt_reg  <= clr_cnt_reg + 1'b1;
          if (clr_cnt_reg == CLR_LAST) begin
            state_reg <= ST_IDLE;
            busy_reg  <= 1'b0;
          end
`else
          state_reg <= ST_IDLE;
`endif
        end

        ST_IDLE: begin
          if (req_valid) begin
            if (req_we) begin
              // A write with no byte lanes enabled completes the handshake
              // without touching the RAM.
              if (|req_be) begin
                ram_cen_reg  <= 1'b0;
                ram_wen_reg  <= ~req_be;
                ram_addr_reg <= req_addr;
                ram_din_reg  <= req_wdata;
              end
            end else begin
              ram_cen_reg  <= 1'b0;
              ram_addr_reg <= req_addr;
              state_reg    <= ST_RD_WAIT;
            end
          end
        end

        ST_RD_WAIT: begin
          // In the first RD_WAIT cycle the read strobe is still on the bus.
          // Once it has dropped, the RAM has presented data on ram_dout.
          if (ram_cen_reg) begin
            rsp_rdata_reg <= ram_dout;
            rsp_valid_reg <= 1'b1;
            state_reg     <= ST_RSP_HOLD;
          end
        end

        ST_RSP_HOLD: begin
          if (rsp_ready) begin
            rsp_valid_reg <= 1'b0;
            state_reg     <= ST_IDLE;
          end
        end

        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule
